mux_rr_select: RTL
==================

MUX_RR_SELECT -- requirements
Module: mux_rr_select

Interface
REQ-001: Parameter MAX_HOLD, default 8, is the maximum number of consecutive cycles one channel may hold the grant; legal range 1..255.
REQ-002: clk  input  1  sole clock; all state updates on its rising edge.
REQ-003: rst_n  input  1  reset, asynchronous and active-low.
REQ-004: req  input  4  per-channel request; bit k requests that downstream 4:1 mux input ik be selected.
REQ-005: done  input  1  consumer end-of-transfer strobe; meaningful only while gnt_valid=1.
REQ-006: s1  output  1  registered select MSB, drives the 4:1 mux s1 directly.
REQ-007: s0  output  1  registered select LSB, drives the 4:1 mux s0 directly.
REQ-008: gnt  output  4  registered one-hot grant; bit {s1,s0} is set when gnt_valid=1, else all zero.
REQ-009: gnt_valid  output  1  registered; high while the mux output is a valid granted channel.

Function
REQ-010: The block SHALL implement a two-state FSM: IDLE and GRANT.
REQ-011: In IDLE with req=0, the block SHALL stay in IDLE and hold s1,s0 at their last values.
REQ-012: In IDLE with req!=0, the block SHALL pick the first set req bit scanning upward from (last+1) mod 4, where last is the most recently granted channel, and wrap 3->0.
REQ-013: The block SHALL register the chosen index into {s1,s0}, set gnt and gnt_valid, update last, clear hold_cnt and enter GRANT on the same edge; latency from a sampled req to gnt_valid=1 is one cycle.
REQ-014: In GRANT, s1, s0 and gnt SHALL remain stable.
REQ-015: hold_cnt SHALL be 8 bits wide, SHALL increment once per GRANT cycle, and SHALL saturate at MAX_HOLD-1.
REQ-016: GRANT SHALL release, returning to IDLE with gnt_valid=0 and gnt=0 on the next edge, when any of these holds: done=1; req[{s1,s0}]=0; hold_cnt=MAX_HOLD-1.
REQ-017: A grant SHALL last at most MAX_HOLD cycles. With MAX_HOLD=1 every grant lasts exactly one cycle.
REQ-018: After every release the block SHALL spend exactly one IDLE cycle with gnt_valid=0 before the next grant, so no two grants are ever back-to-back.
REQ-019: If done and the timeout occur in the same cycle, the block SHALL release once; the outcome is the same as done alone.
REQ-020: Requests from non-granted channels that change during GRANT SHALL have no effect until IDLE.
REQ-021: done while in IDLE SHALL be ignored.
REQ-022: A release caused by a dropped req SHALL still update last, so that channel moves to lowest priority.

Reset
REQ-023: On rst_n=0, the block SHALL immediately and asynchronously set: FSM=IDLE, s1=0, s0=0, gnt=4'b0000, gnt_valid=0, hold_cnt=0, last=3.
REQ-024: Because last resets to 3, the first grant after reset SHALL go to the lowest set req bit starting at channel 0.
REQ-025: Reset asserted mid-GRANT SHALL abort the grant with no completion cycle.
REQ-026: The first grant after rst_n deasserts SHALL occur no earlier than the second rising edge after deassertion.

Verification
REQ-027: Reset, then req=4'b1111 held with done=0 and MAX_HOLD=8 -> grants to channels 0,1,2,3,0,...; each grant lasts 8 cycles; one gap cycle between grants; {s1,s0}=00,01,10,11.
REQ-028: req=4'b0100 only, pulse done in grant cycle 3 -> gnt=4'b0100 and {s1,s0}=10 for 3 cycles, then gnt_valid=0. With req still high, a regrant to channel 2 follows after the gap cycle.
REQ-029: last=1, req=4'b0011 -> grant goes to channel 0 (wrap-around). A following request from channel 1 alone is granted on the next IDLE.
REQ-030: Channel 3 granted and drops req in grant cycle 2 -> release, gnt_valid=0 on the next edge; with req=4'b1001, the next grant is channel 0.
REQ-031: Assert rst_n=0 mid-grant, asynchronously between edges -> outputs go to 0 before the next clock edge. After release, req=4'b1000 -> first grant is channel 3, s1=1, s0=1.
REQ-032: MAX_HOLD=1 with req=4'b0001, and done asserted in the same cycle as the timeout -> 1-cycle grants alternating with 1-cycle gaps, each release counted once.

Source files
------------

// File: rtl/mux_rr_select.sv
// mux_rr_select: round-robin grant FSM producing registered select lines for a 4:1 mux.
// Rev 1.0
`default_nettype none

module mux_rr_select #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic       s1,
  output logic       s0,
  output logic [3:0] gnt,
  output logic       gnt_valid
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [0:0] state;
  logic [7:0] hold_cnt;
  logic [1:0] last;
  logic       armed;
  logic [1:0] pick;
  logic       pick_found;
  logic [1:0] sel;
  logic       release_now;

  assign sel = {s1, s0};
  assign release_now = done | ~req[sel] | (hold_cnt == HOLD_LAST);

  // Scan upward from the channel after the last grant, wrapping 3 -> 0.
  always_comb begin
    logic [1:0] idx;
    pick       = last;
    pick_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      idx = last + 2'(i);
      if (!pick_found && req[idx]) begin
        pick       = idx;
        pick_found = 1'b1;
      end
    end
  end

  // armed blocks a grant on the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      s1        <= 1'b0;
      s0        <= 1'b0;
      gnt       <= 4'b0000;
      gnt_valid <= 1'b0;
      hold_cnt  <= 8'd0;
      last      <= 2'd3;
      armed     <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        IDLE: begin
          if (armed && pick_found) begin
            s1        <= pick[1];
            s0        <= pick[0];
            gnt       <= 4'(4'b0001 << pick);
            gnt_valid <= 1'b1;
            last      <= pick;
            hold_cnt  <= 8'd0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (release_now) begin
            gnt       <= 4'b0000;
            gnt_valid <= 1'b0;
            state     <= IDLE;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
